// File: rtl/serial_to_parallel_rx.sv
`default_nettype none
// ============================================================================
// serial_to_parallel_rx : comma-aligned serial-to-byte deserializer, MSB first
// Revision 1.0
// ============================================================================
module serial_to_parallel_rx #(
   parameter logic [7:0] COMMA     = 8'hBC,
   parameter int         COMMA_NUM = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_rx000,
   output logic       valid_rx000,
   output logic       byte_stb,
   output logic       active
);

   localparam int                c_BC_W   = $clog2(COMMA_NUM + 1);
   localparam logic [c_BC_W-1:0] c_BC_ONE = c_BC_W'(1);
   localparam logic [c_BC_W-1:0] c_BC_TGT = c_BC_W'(COMMA_NUM);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_SYNC   = 2'd2
   } state_t;

   state_t            r_state;
   logic [7:0]        r_sr;
   logic [2:0]        r_bit_cnt;
   logic [c_BC_W-1:0] r_bc_cnt;

   logic [7:0]        w_win;
   logic              w_comma;
   logic              w_bound;
   logic [c_BC_W-1:0] w_bc_next;

   // Window includes the bit being sampled now, so a byte is seen on its last bit
   assign w_win     = {r_sr[6:0], data_in};
   assign w_comma   = (w_win == COMMA);
   assign w_bound   = (r_bit_cnt == 3'd7);
   assign w_bc_next = r_bc_cnt + c_BC_ONE;

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_SEARCH;
         r_sr        <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_bc_cnt    <= '0;
         data_rx000  <= 8'h00;
         valid_rx000 <= 1'b0;
         byte_stb    <= 1'b0;
         active      <= 1'b0;
      end else begin
         r_sr      <= w_win;
         r_bit_cnt <= r_bit_cnt + 3'd1;
         byte_stb  <= 1'b0;
         case (r_state)
            ST_SEARCH: begin
               if (w_comma) begin
                  r_bit_cnt <= 3'd0;
                  r_bc_cnt  <= c_BC_ONE;
                  if (COMMA_NUM == 1) begin
                     r_state <= ST_SYNC;
                     active  <= 1'b1;
                  end else begin
                     r_state <= ST_ALIGN;
                  end
               end
            end
            ST_ALIGN: begin
               if (w_bound) begin
                  if (w_comma) begin
                     r_bc_cnt <= w_bc_next;
                     if (w_bc_next == c_BC_TGT) begin
                        r_state <= ST_SYNC;
                        active  <= 1'b1;
                     end
                  end else begin
                     r_state  <= ST_SEARCH;
                     r_bc_cnt <= '0;
                  end
               end
            end
            ST_SYNC: begin
               // Commas in lock are idle fill: strobed but never flagged valid
               if (w_bound) begin
                  byte_stb <= 1'b1;
                  if (w_comma) begin
                     data_rx000  <= 8'h00;
                     valid_rx000 <= 1'b0;
                  end else begin
                     data_rx000  <= w_win;
                     valid_rx000 <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_SEARCH;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_rx.sv
`default_nettype none
// tb_serial_to_parallel_rx : randomized stimulus against a bit-history reference model
module tb_serial_to_parallel_rx;

   localparam logic [7:0] COMMA     = 8'hBC;
   localparam int         COMMA_NUM = 4;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_rx000;
   logic       valid_rx000;
   logic       byte_stb;
   logic       active;

   int total = 0;
   int bad   = 0;

   serial_to_parallel_rx #(.COMMA(COMMA), .COMMA_NUM(COMMA_NUM)) dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .data_in    (data_in),
      .data_rx000 (data_rx000),
      .valid_rx000(valid_rx000),
      .byte_stb   (byte_stb),
      .active     (active)
   );

   always #5 clk_32f = ~clk_32f;

   // Reference model: "locked" phase measured as bits elapsed since the comma anchor
   int         m_phase;      // 0 hunting, 1 counting aligned commas, 2 locked
   int         m_since;      // bits since last anchor comma
   int         m_commas;
   logic [7:0] m_hist;       // last 8 received bits
   logic [7:0] e_data;
   logic       e_valid;
   logic       e_stb;
   logic       e_active;
   string      phase_tag = "init";

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s [%s] t=%0t: got %0h expected %0h", tag, phase_tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("data",   data_rx000,         e_data);
      chk("valid",  {7'd0, valid_rx000}, {7'd0, e_valid});
      chk("stb",    {7'd0, byte_stb},    {7'd0, e_stb});
      chk("active", {7'd0, active},      {7'd0, e_active});
   endtask

   task automatic model_reset();
      m_phase = 0; m_since = 0; m_commas = 0; m_hist = 8'h00;
      e_data = 8'h00; e_valid = 1'b0; e_stb = 1'b0; e_active = 1'b0;
   endtask

   task automatic model_step(input logic b);
      logic is_comma;
      logic edge8;
      m_hist   = {m_hist[6:0], b};
      is_comma = (m_hist == COMMA);
      m_since  = m_since + 1;
      edge8    = ((m_since % 8) == 0);
      e_stb    = 1'b0;
      if (m_phase == 0) begin
         if (is_comma) begin
            m_since  = 0;
            m_commas = 1;
            if (m_commas >= COMMA_NUM) begin m_phase = 2; e_active = 1'b1; end
            else m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (edge8) begin
            if (is_comma) begin
               m_commas = m_commas + 1;
               if (m_commas >= COMMA_NUM) begin m_phase = 2; e_active = 1'b1; end
            end else begin
               m_phase  = 0;
               m_commas = 0;
            end
         end
      end else if (edge8) begin
         e_stb   = 1'b1;
         e_data  = is_comma ? 8'h00 : m_hist;
         e_valid = !is_comma;
      end
   endtask

   task automatic send_bit(input logic b);
      data_in = b;
      model_step(b);
      @(posedge clk_32f);
      #1;
      check_all();
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_bits_rand(input int n);
      for (int i = 0; i < n; i++) send_bit(1'($urandom));
   endtask

   task automatic do_reset(input int cycles);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      for (int i = 0; i < cycles; i++) begin
         data_in = 1'($urandom);
         @(posedge clk_32f);
         #1;
         check_all();
      end
      @(negedge clk_32f);
      reset = 1'b1;
   endtask

   logic [7:0] rb;

   initial begin
      model_reset();
      // 1: reset with random input, then release and idle in SEARCH
      phase_tag = "reset";
      do_reset(5);
      send_byte(8'h00);
      send_byte(8'h00);

      // 2: junk, four commas, first data byte
      phase_tag = "lock";
      send_bits_rand(3);
      for (int k = 0; k < 4; k++) send_byte(COMMA);
      chk("active_rise", {7'd0, active}, 8'd1);
      send_byte(8'h5A);
      chk("first_stb",   {7'd0, byte_stb}, 8'd1);
      chk("first_data",  data_rx000, 8'h5A);
      chk("first_valid", {7'd0, valid_rx000}, 8'd1);

      // 4: FF, comma, 00 while locked
      phase_tag = "ff_bc_00";
      send_byte(8'hFF);
      chk("ff_data", data_rx000, 8'hFF);
      chk("ff_valid", {7'd0, valid_rx000}, 8'd1);
      send_byte(COMMA);
      chk("bc_data", data_rx000, 8'h00);
      chk("bc_valid", {7'd0, valid_rx000}, 8'd0);
      send_byte(8'h00);
      chk("z_data", data_rx000, 8'h00);
      chk("z_valid", {7'd0, valid_rx000}, 8'd1);

      // 3: three commas then a non-comma aborts alignment
      phase_tag = "abort";
      do_reset(2);
      send_bits_rand(5);
      for (int k = 0; k < 3; k++) send_byte(COMMA);
      send_byte(8'h11);
      chk("abort_active", {7'd0, active}, 8'd0);
      for (int k = 0; k < 4; k++) send_byte(COMMA);
      chk("reacq_active", {7'd0, active}, 8'd1);
      send_byte(8'hA7);
      chk("reacq_data", data_rx000, 8'hA7);

      // 5: comma straddling the nominal byte grid
      phase_tag = "straddle";
      do_reset(1);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      send_byte(8'hBC); send_byte(8'hBC);
      send_byte(COMMA); send_byte(COMMA);
      chk("straddle_active", {7'd0, active}, 8'd1);
      send_byte(8'h3C);
      chk("straddle_data", data_rx000, 8'h3C);
      for (int k = 0; k < 20; k++) begin
         rb = ($urandom_range(0, 4) == 0) ? COMMA : 8'($urandom);
         send_byte(rb);
      end

      // 6: reset four bits into a locked byte
      phase_tag = "midbyte_reset";
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      do_reset(3);
      chk("mid_active", {7'd0, active}, 8'd0);
      send_byte(8'h00); send_byte(8'h00);
      for (int k = 0; k < 4; k++) send_byte(COMMA);
      send_byte(8'hC3);
      chk("mid_data", data_rx000, 8'hC3);

      // Randomized runs: random junk, random comma bursts, random payload
      for (int r = 0; r < 12; r++) begin
         phase_tag = $sformatf("rand%0d", r);
         do_reset($urandom_range(1, 3));
         send_bits_rand($urandom_range(0, 15));
         for (int k = 0; k < int'($urandom_range(1, 6)); k++) send_byte(COMMA);
         if ($urandom_range(0, 2) == 0) send_bits_rand($urandom_range(1, 7));
         for (int k = 0; k < 24; k++) begin
            rb = ($urandom_range(0, 5) == 0) ? COMMA : 8'($urandom);
            send_byte(rb);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
